// File: rtl/vend_ctrl.sv
// Vending controller: accumulates coin credit, requests a vend over a
// valid/ack handshake, then pays out change or a refund one unit per
// accepted hopper handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no credit held, coins accepted
// COLLECT | 0 < credit < PRICE, coins accepted, cancel refunds
// VEND    | vend_req high, waiting for vend_ack; coins rejected
// CHANGE  | paying out remaining credit one unit per change_ready
module vend_ctrl #(
    parameter int CREDIT_W = 6,
    parameter int PRICE    = 3,
    parameter int VAL_01   = 2,
    parameter int VAL_10   = 1,
    parameter int VAL_11   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coins,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                change_ready,
    output logic                vend_req,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;
    localparam logic [1:0] CHANGE  = 2'd3;

    localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_X    = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_N    = CREDIT_W'(PRICE);

    if (PRICE < 1 || PRICE > (2**CREDIT_W) - 1) begin : g_price_check
        $error("vend_ctrl: PRICE out of range 1..2^CREDIT_W-1");
    end

    logic [1:0]          state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                reject_nxt;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   new_credit;

    // Map coin code to its credit value, one bit wider so the sum cannot wrap
    always_comb begin
        coin_val = '0;
        case (coins)
            2'b01:   coin_val = (CREDIT_W+1)'(VAL_01);
            2'b10:   coin_val = (CREDIT_W+1)'(VAL_10);
            2'b11:   coin_val = (CREDIT_W+1)'(VAL_11);
            default: coin_val = '0;
        endcase
        coin_sum = {1'b0, credit} + coin_val;
    end

    // Next-state, next-credit and coin-return decision
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        reject_nxt = 1'b0;
        new_credit = {1'b0, credit};
        case (state)
            IDLE, COLLECT: begin
                // cancel only means something once credit is held; in IDLE
                // it is ignored and a same-cycle coin is taken normally
                if (state == COLLECT && cancel) begin
                    state_nxt  = CHANGE;
                    reject_nxt = (coins != 2'b00);
                end else begin
                    if (coins != 2'b00) begin
                        if (coin_sum <= MAX_CREDIT) begin
                            new_credit = coin_sum;
                        end else begin
                            reject_nxt = 1'b1;
                        end
                    end
                    credit_nxt = new_credit[CREDIT_W-1:0];
                    if (new_credit >= PRICE_X) begin
                        state_nxt = VEND;
                    end else if (new_credit != '0) begin
                        state_nxt = COLLECT;
                    end
                end
            end
            VEND: begin
                reject_nxt = (coins != 2'b00);
                if (vend_ack) begin
                    credit_nxt = credit - PRICE_N;
                    state_nxt  = (credit != PRICE_N) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                reject_nxt = (coins != 2'b00);
                if (credit == '0) begin
                    state_nxt = IDLE;
                end else if (change_ready) begin
                    credit_nxt = credit - 1'b1;
                    if (credit == CREDIT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    // State, credit and registered coin-return pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            coin_reject <= reject_nxt;
        end
    end

    // Moore outputs decoded from state
    always_comb begin
        vend_req     = (state == VEND);
        change_pulse = (state == CHANGE) && (credit != '0);
        busy         = (state == VEND) || (state == CHANGE);
    end

endmodule
